seg7_scan_driver: RTL and testbench

//  Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits sharing one segment bus.

---
 rtl/seg7_scan_driver.sv | 154 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scan driver with a double-buffered display value.
// Define SEG7_SCAN_DP_EN to add per-digit decimal-point mask input and dp output.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    blank_lz,
`ifdef SEG7_SCAN_DP_EN
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic                    dp,
`endif
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick,
    output logic                    pending
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = $clog2(REFRESH_DIV);

    logic [DIV_W-1:0]          div_q, div_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   shadow_q, shadow_d, active_q, active_d;
    logic                      pending_q, pending_d;
    logic [6:0]                seg_q, seg_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d;
    logic                      frame_tick_q, frame_tick_d;
    logic                      step, last, boundary;
    logic [3:0]                nib;
    logic                      zero_above, blank_sel;
`ifdef SEG7_SCAN_DP_EN
    logic [NUM_DIGITS-1:0]     shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
    logic                      dp_q, dp_d, dp_sel;
`endif

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b0000001;  4'h1: hex7 = 7'b1001111;
            4'h2: hex7 = 7'b0010010;  4'h3: hex7 = 7'b0000110;
            4'h4: hex7 = 7'b1001100;  4'h5: hex7 = 7'b0100100;
            4'h6: hex7 = 7'b0100000;  4'h7: hex7 = 7'b0001111;
            4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0000100;
            4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b1100000;
            4'hC: hex7 = 7'b0110001;  4'hD: hex7 = 7'b1000010;
            4'hE: hex7 = 7'b0110000;  default: hex7 = 7'b0111000;
        endcase
    endfunction

    always_comb begin
        step      = (div_q == DIV_W'(REFRESH_DIV - 1));
        last      = (idx_q == IDX_W'(NUM_DIGITS - 1));
        boundary  = step && last;
        div_d     = step ? '0 : div_q + 1'b1;
        idx_d     = step ? (last ? '0 : idx_q + 1'b1) : idx_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
`ifdef SEG7_SCAN_DP_EN
        shadow_dp_d = shadow_dp_q;
        active_dp_d = active_dp_q;
`endif
        // A load landing on the boundary bypasses the shadow so it is not held back a frame.
        if (load) begin
            shadow_d  = value;
            pending_d = 1'b1;
`ifdef SEG7_SCAN_DP_EN
            shadow_dp_d = dp_mask;
`endif
        end
        if (boundary && load) begin
            active_d  = value;
            pending_d = 1'b0;
`ifdef SEG7_SCAN_DP_EN
            active_dp_d = dp_mask;
`endif
        end else if (boundary && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
`ifdef SEG7_SCAN_DP_EN
            active_dp_d = shadow_dp_q;
`endif
        end
        frame_tick_d = boundary;
    end

    // Walk from the top digit down so zero_above covers nibbles NUM_DIGITS-1..i.
    always_comb begin
        nib        = '0;
        zero_above = 1'b1;
        blank_sel  = 1'b0;
`ifdef SEG7_SCAN_DP_EN
        dp_sel     = 1'b0;
`endif
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (active_q[4*i +: 4] == 4'h0);
            if (idx_q == IDX_W'(i)) begin
                nib       = active_q[4*i +: 4];
                blank_sel = blank_lz && (i != 0) && zero_above;
`ifdef SEG7_SCAN_DP_EN
                dp_sel    = active_dp_q[i];
`endif
            end
        end
        seg_d = blank_sel ? 7'b1111111 : hex7(nib);
        for (int i = 0; i < NUM_DIGITS; i++)
            an_d[i] = !((idx_q == IDX_W'(i)) && !blank_sel);
`ifdef SEG7_SCAN_DP_EN
        dp_d = !(dp_sel && !blank_sel);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
            seg_q        <= 7'b1111111;
            an_q         <= '1;
            frame_tick_q <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
            shadow_dp_q  <= '0;
            active_dp_q  <= '0;
            dp_q         <= 1'b1;
`endif
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
`ifdef SEG7_SCAN_DP_EN
            shadow_dp_q  <= shadow_dp_d;
            active_dp_q  <= active_dp_d;
            dp_q         <= dp_d;
`endif
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;
    assign pending    = pending_q;
`ifdef SEG7_SCAN_DP_EN
    assign dp         = dp_q;
`endif
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 4-cycle refresh); expected outputs are
// queued from a behavioural model as each cycle's stimulus is applied.
module tb_seg7_scan_driver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_tick, pending;
`ifdef SEG7_SCAN_DP_EN
    logic [3:0]  dp_mask = '0;
    logic        dp;
`endif

    seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .blank_lz(blank_lz),
`ifdef SEG7_SCAN_DP_EN
        .dp_mask(dp_mask), .dp(dp),
`endif
        .seg(seg), .an(an), .frame_tick(frame_tick), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic       ft;
        logic       pend;
        logic       dp;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_bad = 0;

    logic [6:0] hex_tbl [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    int          m_div, m_idx;
    logic [15:0] m_shadow, m_active;
    logic        m_pending;
    logic [3:0]  m_dpsh, m_dpact;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_div = 0; m_idx = 0; m_shadow = '0; m_active = '0; m_pending = 1'b0;
        m_dpsh = '0; m_dpact = '0;
        q.delete();
    endtask

    function automatic logic at_boundary();
        return (m_div == 3) && (m_idx == 3);
    endfunction

    // One clock: predict this edge's outputs, advance the model, then compare.
    task automatic tick();
        exp_t e, o;
        logic bl, bnd;
        logic [3:0] dpm;
`ifdef SEG7_SCAN_DP_EN
        dpm = dp_mask;
`else
        dpm = '0;
`endif
        bl     = blank_lz && (m_idx > 0) && ((m_active >> (4*m_idx)) == 16'h0);
        e.seg  = bl ? 7'b1111111 : hex_tbl[m_active[4*m_idx +: 4]];
        e.an   = bl ? 4'b1111 : ~(4'b0001 << m_idx);
        e.dp   = bl ? 1'b1 : ~m_dpact[m_idx];
        bnd    = at_boundary();
        e.ft   = bnd;
        if (bnd && load) begin
            m_active = value; m_shadow = value; m_pending = 1'b0;
            m_dpact = dpm; m_dpsh = dpm;
        end else if (bnd && m_pending) begin
            m_active = m_shadow; m_dpact = m_dpsh; m_pending = 1'b0;
            if (load) begin m_shadow = value; m_dpsh = dpm; m_pending = 1'b1; end
        end else if (load) begin
            m_shadow = value; m_dpsh = dpm; m_pending = 1'b1;
        end
        e.pend = m_pending;
        if (m_div == 3) begin
            m_div = 0;
            m_idx = (m_idx == 3) ? 0 : m_idx + 1;
        end else begin
            m_div++;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        o = q.pop_front();
        chk("seg", 32'(seg), 32'(o.seg));
        chk("an", 32'(an), 32'(o.an));
        chk("frame_tick", 32'(frame_tick), 32'(o.ft));
        chk("pending", 32'(pending), 32'(o.pend));
`ifdef SEG7_SCAN_DP_EN
        chk("dp", 32'(dp), 32'(o.dp));
`endif
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1; value = v;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_boundary();
        for (int k = 0; k < 40 && !at_boundary(); k++) tick();
        chk("boundary_reached", 32'(at_boundary()), 32'd1);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run(5);
        // Reset mid-frame with an unshown shadow value
        do_load(16'h9876);
        run(2);
        rst = 1'b1;
        #1;
        chk("rst_seg", 32'(seg), 32'h7f);
        chk("rst_an", 32'(an), 32'hf);
        chk("rst_frame_tick", 32'(frame_tick), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
`ifdef SEG7_SCAN_DP_EN
        chk("rst_dp", 32'(dp), 32'd1);
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        tick();
        chk("first_an", 32'(an), 32'he);
        chk("first_seg", 32'(seg), 32'h01);
        run(20);

        // Scan order with 1234
`ifdef SEG7_SCAN_DP_EN
        dp_mask = 4'b0010;
`endif
        do_load(16'h1234);
        wait_boundary();
        run(40);

        // Double buffer: mid-frame load holds old value until the boundary
        run(5);
        do_load(16'hABCD);
        chk("pending_mid", 32'(pending), 32'd1);
        run(30);

        // Last load in a frame wins
        wait_boundary();
        tick();
        do_load(16'h1111);
        run(3);
        do_load(16'h2222);
        run(25);

        // Load on the boundary cycle bypasses the shadow
        wait_boundary();
        do_load(16'h5A5A);
        chk("bypass_pending", 32'(pending), 32'd0);
        run(20);

        // Leading-zero blanking
        blank_lz = 1'b1;
        wait_boundary();
        do_load(16'h0050);
        run(20);
        wait_boundary();
        do_load(16'h0000);
        run(20);
        wait_boundary();
        do_load(16'hF008);
        run(20);

        // Random loads, masks and blanking
        for (int k = 0; k < 300; k++) begin
            load     = ($urandom_range(0, 7) == 0);
            value    = ($urandom_range(0, 3) == 0) ? 16'(32'h000F << (4*$urandom_range(0, 3)))
                                                   : 16'($urandom);
            blank_lz = 1'(($urandom_range(0, 1)));
`ifdef SEG7_SCAN_DP_EN
            dp_mask  = 4'($urandom);
`endif
            tick();
        end
        load = 1'b0;
        run(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
